// File: rtl/ram_copy_dma_pkg.sv
// Shared types and helpers for the RAM block copy engine.
package ram_copy_dma_pkg;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    // Base + offset, wrapped to an aw-bit address space.
    function automatic logic [31:0] wrap_add(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned aw);
        logic [31:0] mask;
        mask = (aw >= 32) ? '1 : ((32'd1 << aw) - 32'd1);
        return (a + b) & mask;
    endfunction

endpackage

// File: rtl/ram_copy_dma_addr_gen.sv
// Base+offset address generator; counts up from base, or down from
// base+last when desc_i is set. One instance per RAM port.
module ram_copy_addr_gen
    import ram_copy_dma_pkg::*;
#(
    parameter int N = ADDR_W
) (
    input  logic [N-1:0] base_i,
    input  logic [N-1:0] offset_i,
    input  logic [N-1:0] last_i,
    input  logic         desc_i,
    output logic [N-1:0] addr_o
);

    logic [N-1:0] step;

    assign step   = desc_i ? (last_i - offset_i) : offset_i;
    assign addr_o = N'(wrap_add(32'(base_i), 32'(step), N));

endmodule

// File: rtl/ram_copy_dma.sv
// Block copy engine driving both ports of a synchronous dual-port RAM:
// reads on port A, writes on port B one cycle later.
// Optional build macro RAM_COPY_DMA_OVERLAP_SAFE_EN: copy descending when
// the destination overlaps the tail of the source (memmove semantics).
module ram_copy_dma
    import ram_copy_dma_pkg::*;
#(
    parameter int N = ADDR_W,
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [N-1:0] SRC_ADDR,
    input  logic [N-1:0] DST_ADDR,
    input  logic [N:0]   LEN,
    output logic         BUSY,
    output logic         DONE,
    output logic         CS,
    output logic         WR_RD_A,
    output logic [N-1:0] ADDR_A,
    output logic [W-1:0] WDATA_A,
    output logic         WR_RD_B,
    output logic [N-1:0] ADDR_B,
    output logic [W-1:0] WDATA_B,
    input  logic [W-1:0] RDATA_A,
    input  logic [W-1:0] RDATA_B
);

    localparam logic [N:0] LEN_MAX = {1'b1, {N{1'b0}}};

    state_e       state_q, state_d;
    logic [N-1:0] src_q, src_d, dst_q, dst_d;
    logic [N:0]   len_q, len_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic         wr_pend_q, wr_pend_d;
    logic         desc_q, desc_d;
    logic [N:0]   len_clamp, len_m1;
    logic         start_desc;
    logic         addr_en;
    logic [N-1:0] rd_addr, wr_addr;
    logic         unused_rdata_b;

    assign len_clamp = (LEN > LEN_MAX) ? LEN_MAX : LEN;
    assign len_m1    = len_q - (N+1)'(1);

`ifdef RAM_COPY_DMA_OVERLAP_SAFE_EN
    // Destination inside the source's tail: ascending would clobber
    // unread source words, so walk both ranges top-down instead.
    logic [N-1:0] diff;
    assign diff       = DST_ADDR - SRC_ADDR;
    assign start_desc = (diff != '0) && ({1'b0, diff} < len_clamp);
`else
    assign start_desc = 1'b0;
`endif

    ram_copy_addr_gen #(.N(N)) u_rd_gen (
        .base_i  (src_q),
        .offset_i(rd_cnt_q[N-1:0]),
        .last_i  (len_m1[N-1:0]),
        .desc_i  (desc_q),
        .addr_o  (rd_addr)
    );

    ram_copy_addr_gen #(.N(N)) u_wr_gen (
        .base_i  (dst_q),
        .offset_i(wr_cnt_q[N-1:0]),
        .last_i  (len_m1[N-1:0]),
        .desc_i  (desc_q),
        .addr_o  (wr_addr)
    );

    // Next-state, counter updates and registered-state output decode.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        wr_pend_d = wr_pend_q;
        desc_d    = desc_q;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        CS        = 1'b1;
        WR_RD_B   = 1'b0;
        addr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (len_clamp != '0) begin
                        src_d     = SRC_ADDR;
                        dst_d     = DST_ADDR;
                        len_d     = len_clamp;
                        rd_cnt_d  = '0;
                        wr_cnt_d  = '0;
                        wr_pend_d = 1'b0;
                        desc_d    = start_desc;
                        state_d   = RUN;
                    end else begin
                        state_d   = FIN;
                    end
                end
            end
            RUN: begin
                BUSY      = 1'b1;
                CS        = 1'b0;
                WR_RD_B   = wr_pend_q;
                addr_en   = 1'b1;
                rd_cnt_d  = rd_cnt_q + (N+1)'(1);
                wr_pend_d = 1'b1;
                if (wr_pend_q) wr_cnt_d = wr_cnt_q + (N+1)'(1);
                if (rd_cnt_q == len_m1) state_d = DRAIN;
            end
            DRAIN: begin
                // Last read's data arrives now; write it, read is don't-care.
                BUSY    = 1'b1;
                CS      = 1'b0;
                WR_RD_B = 1'b1;
                addr_en = 1'b1;
                state_d = FIN;
            end
            FIN: begin
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ADDR_A         = addr_en ? rd_addr : '0;
    assign ADDR_B         = addr_en ? wr_addr : '0;
    assign WR_RD_A        = 1'b0;
    assign WDATA_A        = '0;
    assign WDATA_B        = RDATA_A;
    assign unused_rdata_b = ^RDATA_B;

    // State and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            wr_pend_q <= 1'b0;
            desc_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_pend_q <= wr_pend_d;
            desc_q    <= desc_d;
        end
    end

endmodule

// File: tb/tb_ram_copy_dma.sv
// Directed bench for ram_copy_dma with a behavioural dual-port RAM.
module tb_ram_copy_dma;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [3:0] SRC_ADDR, DST_ADDR;
    logic [4:0] LEN;
    logic       BUSY, DONE, CS, WR_RD_A, WR_RD_B;
    logic [3:0] ADDR_A, ADDR_B;
    logic [7:0] WDATA_A, WDATA_B, RDATA_A, RDATA_B;

    logic [7:0] mem [16];
    logic [7:0] snap [16];
    logic       pre_we;
    logic [3:0] pre_addr;
    logic [7:0] pre_data;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    ram_copy_dma #(.N(4), .W(8)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .CS(CS),
        .WR_RD_A(WR_RD_A), .ADDR_A(ADDR_A), .WDATA_A(WDATA_A),
        .WR_RD_B(WR_RD_B), .ADDR_B(ADDR_B), .WDATA_B(WDATA_B),
        .RDATA_A(RDATA_A), .RDATA_B(RDATA_B)
    );

    // RAM model: registered read, read-before-write on collision.
    always @(posedge CLK) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (!CS && WR_RD_B) mem[ADDR_B] <= WDATA_B;
        if (!CS) RDATA_A <= mem[ADDR_A];
    end
    assign RDATA_B = 8'h00;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = 4'(a); pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    // Launch a copy and check the handshake cycle by cycle; eff is the
    // word count after clamping, restart_c re-pulses START in that cycle.
    task automatic run_copy(input logic [3:0] src, input logic [3:0] dst,
                            input logic [4:0] len, input int eff, input int restart_c);
        logic busy_e, done_e;
        SRC_ADDR = src; DST_ADDR = dst; LEN = len; START = 1'b1;
        tick();
        START = 1'b0;
        for (int c = 1; c <= eff + 3; c++) begin
            busy_e = (eff != 0) && (c <= eff + 1);
            done_e = (eff == 0) ? (c == 1) : (c == eff + 2);
            chk($sformatf("busy c%0d", c), 32'(BUSY), 32'(busy_e));
            chk($sformatf("done c%0d", c), 32'(DONE), 32'(done_e));
            chk($sformatf("cs c%0d", c), 32'(CS), 32'(!busy_e));
            chk("wr_rd_a", 32'(WR_RD_A), 32'd0);
            if (c == restart_c) START = 1'b1;
            tick();
            START = 1'b0;
        end
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; SRC_ADDR = '0; DST_ADDR = '0; LEN = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        tick(); tick();

        // Reset state
        chk("rst busy", 32'(BUSY), 32'd0);
        chk("rst done", 32'(DONE), 32'd0);
        chk("rst cs", 32'(CS), 32'd1);
        chk("rst wr_rd_a", 32'(WR_RD_A), 32'd0);
        chk("rst wr_rd_b", 32'(WR_RD_B), 32'd0);
        chk("rst addr_a", 32'(ADDR_A), 32'd0);
        chk("rst addr_b", 32'(ADDR_B), 32'd0);
        chk("rst wdata_a", 32'(WDATA_A), 32'd0);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) preload(i, 8'(8'h80 + i));

        // 1: plain copy 0..2 -> 8..10
        preload(0, 8'hAA); preload(1, 8'hBB); preload(2, 8'hCC);
        run_copy(4'd0, 4'd8, 5'd3, 3, 0);
        chk("t1 m8", 32'(mem[8]), 32'hAA);
        chk("t1 m9", 32'(mem[9]), 32'hBB);
        chk("t1 m10", 32'(mem[10]), 32'hCC);
        chk("t1 m11", 32'(mem[11]), 32'h8B);
        chk("t1 m0", 32'(mem[0]), 32'hAA);
        chk("t1 m2", 32'(mem[2]), 32'hCC);

        // 2: LEN=0, no RAM access
        run_copy(4'd5, 4'd9, 5'd0, 0, 0);
        chk("t2 m9", 32'(mem[9]), 32'hBB);

        // 3: source wraps past the top of memory
        preload(14, 8'h11); preload(15, 8'h22); preload(0, 8'h33); preload(1, 8'h44);
        run_copy(4'd14, 4'd4, 5'd4, 4, 0);
        chk("t3 m4", 32'(mem[4]), 32'h11);
        chk("t3 m5", 32'(mem[5]), 32'h22);
        chk("t3 m6", 32'(mem[6]), 32'h33);
        chk("t3 m7", 32'(mem[7]), 32'h44);

        // 4a: START during BUSY is ignored
        for (int i = 0; i < 16; i++) snap[i] = mem[i];
        run_copy(4'd0, 4'd10, 5'd5, 5, 2);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t4 m%0d", 10 + i), 32'(mem[10 + i]), 32'(snap[i]));

        // 4b: reset in cycle 3 aborts with no DONE
        SRC_ADDR = 4'd0; DST_ADDR = 4'd8; LEN = 5'd5; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        chk("t4 busy c2", 32'(BUSY), 32'd1);
        tick();
        RST = 1'b1;
        tick();
        chk("t4 abort cs", 32'(CS), 32'd1);
        chk("t4 abort busy", 32'(BUSY), 32'd0);
        chk("t4 abort done", 32'(DONE), 32'd0);
        chk("t4 abort wr_rd_b", 32'(WR_RD_B), 32'd0);
        chk("t4 abort addr_a", 32'(ADDR_A), 32'd0);
        chk("t4 abort addr_b", 32'(ADDR_B), 32'd0);
        RST = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t4 post done", 32'(DONE), 32'd0);
            chk("t4 post busy", 32'(BUSY), 32'd0);
        end

        // 5: overlapping forward copy, DST=SRC+2
        preload(0, 8'd1); preload(1, 8'd2); preload(2, 8'd3); preload(3, 8'd4);
        run_copy(4'd0, 4'd2, 5'd4, 4, 0);
`ifdef RAM_COPY_DMA_OVERLAP_SAFE_EN
        chk("t5 m2", 32'(mem[2]), 32'd1);
        chk("t5 m3", 32'(mem[3]), 32'd2);
        chk("t5 m4", 32'(mem[4]), 32'd3);
        chk("t5 m5", 32'(mem[5]), 32'd4);
`else
        chk("t5 m2", 32'(mem[2]), 32'd1);
        chk("t5 m3", 32'(mem[3]), 32'd2);
        chk("t5 m4", 32'(mem[4]), 32'd1);
        chk("t5 m5", 32'(mem[5]), 32'd2);
`endif

        // 6: DST=SRC+1 relies on read-old-value collision semantics
        preload(0, 8'd5); preload(1, 8'd6); preload(2, 8'd7);
        run_copy(4'd0, 4'd1, 5'd3, 3, 0);
        chk("t6 m1", 32'(mem[1]), 32'd5);
        chk("t6 m2", 32'(mem[2]), 32'd6);
        chk("t6 m3", 32'(mem[3]), 32'd7);

        // 7: LEN above 2^N clamps to the whole memory (copy onto itself)
        for (int i = 0; i < 16; i++) snap[i] = mem[i];
        run_copy(4'd3, 4'd3, 5'd20, 16, 0);
        chk("t7 m3", 32'(mem[3]), 32'(snap[3]));
        chk("t7 m2", 32'(mem[2]), 32'(snap[2]));
        chk("t7 m15", 32'(mem[15]), 32'(snap[15]));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
